// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: default opcodes,
// FSM encoding and instruction field slicing helpers.
package stage_if_pkg;

  localparam logic [5:0]  HALT_OP_DEFAULT  = 6'h3F;
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetchState_t;

  function automatic logic [5:0] opField(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] rsField(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] rtField(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] rdField(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [5:0] funcField(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [15:0] immField(input logic [31:0] instr);
    return instr[15:0];
  endfunction

endpackage

// File: rtl/stage_if_latch.sv
// IF/ID pipeline register: holds PC+4, the raw instruction word and a valid
// flag. Flush injects a bubble and takes priority over a load.
module if_id_latch #(
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] inPc,
  input  logic [31:0] inInstr,
  output logic [31:0] outPc,
  output logic [31:0] outInstr,
  output logic        valid
);

  // Latch update: reset > flush (bubble) > load > hold.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      outPc    <= 32'h0;
      outInstr <= NOP_INSN;
      valid    <= 1'b0;
    end else if (load) begin
      outPc    <= inPc;
      outInstr <= inInstr;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC register, next-PC selection, HALT FSM, fetch
// counter and the IF/ID latch feeding decode. The instruction memory is
// external with a registered read, so imem_addr is driven from the next PC.
module stage_if
  import stage_if_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = HALT_OP_DEFAULT,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              takeBranch,
  input  logic [31:0]       branchTarget,
  input  logic              jump,
  input  logic [31:0]       jumpTarget,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       outPc,
  output logic [31:0]       outInstr,
  output logic [5:0]        opCode,
  output logic [5:0]        inFunction,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       immediate,
  output logic              valid,
  output logic              halted,
  output logic [31:0]       fetchCount
);

  logic [31:0] pcQ;
  logic [31:0] pcNext;
  fetchState_t stateQ;
  fetchState_t stateNext;
  logic        redirect;
  logic        normalLoad;
  logic        haltSeen;
  logic        flush;
  logic [31:0] fetchCountQ;

  // Per-cycle control decode: what kind of cycle this is.
  always_comb begin
    redirect   = takeBranch | jump;
    normalLoad = !redirect && (stateQ == RUN) && !stall;
    haltSeen   = normalLoad && (opField(imem_data) == HALT_OP);
    flush      = redirect || (stateQ == HALTED);
  end

  // Next-PC priority: reset > branch > jump > halted hold > stall hold > +4.
  // A freshly seen HALT also holds so pcQ rests on the HALT address.
  always_comb begin
    pcNext = pcQ + 32'd4;
    if (reset)
      pcNext = RESET_PC;
    else if (takeBranch)
      pcNext = branchTarget;
    else if (jump)
      pcNext = jumpTarget;
    else if (stateQ == HALTED || stall || haltSeen)
      pcNext = pcQ;
  end

  // Memory registers this address, so imem_data always reflects mem[pcQ].
  assign imem_addr = pcNext[ADDR_W+1:2];

  // PC register.
  always_ff @(posedge clk) begin
    if (reset)
      pcQ <= RESET_PC;
    else
      pcQ <= pcNext;
  end

  // FSM next state: redirect always resumes, a loaded HALT stops fetching.
  always_comb begin
    stateNext = stateQ;
    if (redirect)
      stateNext = RUN;
    else if (haltSeen)
      stateNext = HALTED;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      stateQ <= RUN;
    else
      stateQ <= stateNext;
  end

  // Count instructions actually delivered into IF/ID (wraps naturally).
  always_ff @(posedge clk) begin
    if (reset)
      fetchCountQ <= 32'h0;
    else if (normalLoad)
      fetchCountQ <= fetchCountQ + 32'd1;
  end

  if_id_latch #(
    .NOP_INSN (NOP_INSN)
  ) ifIdLatch (
    .clk      (clk),
    .reset    (reset),
    .load     (normalLoad),
    .flush    (flush),
    .inPc     (pcQ + 32'd4),
    .inInstr  (imem_data),
    .outPc    (outPc),
    .outInstr (outInstr),
    .valid    (valid)
  );

  assign opCode     = opField(outInstr);
  assign inFunction = funcField(outInstr);
  assign rs         = rsField(outInstr);
  assign rt         = rtField(outInstr);
  assign rd         = rdField(outInstr);
  assign immediate  = immField(outInstr);
  assign halted     = (stateQ == HALTED);
  assign fetchCount = fetchCountQ;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if with a registered-read instruction memory model
// and a scoreboard of expected IF/ID contents per clock.
module tb_stage_if;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              takeBranch;
  logic [31:0]       branchTarget;
  logic              jump;
  logic [31:0]       jumpTarget;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemData;
  logic [31:0]       outPc;
  logic [31:0]       outInstr;
  logic [5:0]        opCode;
  logic [5:0]        inFunction;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       immediate;
  logic              valid;
  logic              halted;
  logic [31:0]       fetchCount;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        h;
  } expect_t;

  expect_t     sb[$];
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expCount = 32'h0;
  logic [31:0] haltWord = {6'h3F, 26'h0};

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imemData <= mem[imemAddr];

  stage_if #(
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .takeBranch   (takeBranch),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .imem_addr    (imemAddr),
    .imem_data    (imemData),
    .outPc        (outPc),
    .outInstr     (outInstr),
    .opCode       (opCode),
    .inFunction   (inFunction),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .immediate    (immediate),
    .valid        (valid),
    .halted       (halted),
    .fetchCount   (fetchCount)
  );

  function automatic logic [31:0] memWord(input int i);
    logic [31:0] w;
    w = {6'h0A, 5'(i), 5'(i + 7), 16'(i * 257 + 51)};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push its expected IF/ID result, compare after the edge.
  task automatic step(input logic st, input logic br, input logic jp,
                      input logic [31:0] tgt, input logic expV,
                      input logic [31:0] expI, input logic [31:0] expP,
                      input logic expH, input logic inc);
    expect_t e;
    stall        = st;
    takeBranch   = br;
    jump         = jp;
    branchTarget = br ? tgt : 32'h0000_03C0;
    jumpTarget   = jp ? tgt : 32'h0000_0200;
    if (inc) expCount = expCount + 32'd1;
    sb.push_back('{v: expV, instr: expI, pc: expP, h: expH});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid", {31'b0, valid}, {31'b0, e.v});
    chk("outInstr", outInstr, e.instr);
    if (e.v) chk("outPc", outPc, e.pc);
    chk("opCode", {26'b0, opCode}, {26'b0, e.instr[31:26]});
    chk("rs", {27'b0, rs}, {27'b0, e.instr[25:21]});
    chk("rt", {27'b0, rt}, {27'b0, e.instr[20:16]});
    chk("rd", {27'b0, rd}, {27'b0, e.instr[15:11]});
    chk("inFunction", {26'b0, inFunction}, {26'b0, e.instr[5:0]});
    chk("immediate", {16'b0, immediate}, {16'b0, e.instr[15:0]});
    chk("halted", {31'b0, halted}, {31'b0, e.h});
    chk("fetchCount", fetchCount, expCount);
    $display("step st=%0b br=%0b jp=%0b tgt=%h -> valid=%0b instr=%h pc=%h halted=%0b cnt=%0d",
             st, br, jp, tgt, valid, outInstr, outPc, halted, fetchCount);
  endtask

  // Reset for two edges (stall level left as given) and check reset state.
  task automatic doReset(input logic st);
    reset      = 1'b1;
    stall      = st;
    takeBranch = 1'b0;
    jump       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_outPc", outPc, 32'h0);
    chk("rst_outInstr", outInstr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_fetchCount", fetchCount, 32'h0);
    chk("rst_imem_addr", {22'b0, imemAddr}, 32'h0);
    $display("reset st=%0b -> valid=%0b pc=%h cnt=%0d imem_addr=%0d",
             st, valid, outPc, fetchCount, imemAddr);
    reset    = 1'b0;
    stall    = 1'b0;
    expCount = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = memWord(i);
    reset = 1'b1; stall = 1'b0; takeBranch = 1'b0; jump = 1'b0;
    branchTarget = 32'h0; jumpTarget = 32'h0;

    // Straight-line fetch of I0..I3.
    doReset(1'b0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, memWord(i), 32'(4 * i + 4), 0, 1);

    // Stall three cycles while I1 is latched.
    doReset(1'b0);
    step(0, 0, 0, 0, 1, memWord(0), 32'd4, 0, 1);
    step(0, 0, 0, 0, 1, memWord(1), 32'd8, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 1, memWord(1), 32'd8, 0, 0);
    step(0, 0, 0, 0, 1, memWord(2), 32'd12, 0, 1);

    // Taken branch to 0x40: bubble, then mem[16], mem[17].
    step(0, 1, 0, 32'h40, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 1, memWord(16), 32'h44, 0, 1);
    step(0, 0, 0, 0, 1, memWord(17), 32'h48, 0, 1);

    // Jump together with stall: jump wins.
    step(1, 0, 1, 32'h80, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 1, memWord(32), 32'h84, 0, 1);

    // HALT at 0x0C.
    mem[3] = haltWord;
    doReset(1'b0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1, memWord(i), 32'(4 * i + 4), 0, 1);
    step(0, 0, 0, 0, 1, haltWord, 32'd16, 1, 1);
    chk("halt_imem_addr", {22'b0, imemAddr}, 32'd3);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    chk("halted_imem_addr", {22'b0, imemAddr}, 32'd3);
    // Redirect out of HALTED.
    step(0, 1, 0, 32'h20, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 1, memWord(8), 32'h24, 0, 1);

    // Reset during a stall.
    step(1, 0, 0, 0, 1, memWord(8), 32'h24, 0, 0);
    doReset(1'b1);

    // Reach HALT again, then reset while halted.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1, memWord(i), 32'(4 * i + 4), 0, 1);
    step(0, 0, 0, 0, 1, haltWord, 32'd16, 1, 1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    doReset(1'b0);
    step(0, 0, 0, 0, 1, memWord(0), 32'd4, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
